wts_ram_arbiter: RTL and testbench
==================================

# wts_ram_arbiter

Arbitrates the single-port 640×8 wave-table RAM (5 channels × 128 words) between the CPU bus interface and the five tone-generator channel fetch units. It serialises accesses with a req/ack handshake, builds physical RAM addresses, and returns read data to the winning requester. It sits between the register/bus decoder and channel sequencers on one side and the wave-table RAM on the other.

## Interface
- `RAM_WORDS`, 640, number of valid RAM words; CPU accesses at or above this are out of range
- `clk`  in  1  system clock, all logic on rising edge
- `nreset`  in  1  asynchronous active-low reset
- `cpu_req`  in  1  CPU access request; held high until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read; sampled with grant
- `cpu_a`  in  10  CPU physical RAM address
- `cpu_d`  in  8  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_q`  out  8  CPU read data, valid while `cpu_ack` = 1 and held until the next CPU read completes
- `ch_req`  in  5  per-channel read request, bit n = channel n
- `ch_addr`  in  35  7-bit wave offsets, bits [7n+6:7n] = channel n
- `ch_ack`  out  5  one-hot completion pulse
- `ch_q`  out  8  channel read data, valid while any `ch_ack` bit = 1
- `sram_we`  out  1  RAM write enable
- `sram_a`  out  10  RAM address
- `sram_d`  out  8  RAM write data
- `sram_q`  in  8  RAM registered read data, one cycle after address is captured

## Operation
- FSM states: IDLE, ACCESS, READ, DONE. Transitions IDLE→ACCESS (any eligible request), ACCESS→READ, READ→DONE, DONE→IDLE. All transitions are unconditional except the one out of IDLE.
- IDLE: choose a winner from the six requesters in order ch0..ch4, cpu, starting at the round-robin pointer `rr`. Register the winner id, `sram_a`, `sram_d`, and a pending-write flag. Set `rr` = winner+1, wrapping from 6 to 0.
- Channel n address: n×128 + offset (10 bits; never overflows, maximum 639). Channel accesses are always reads.
- CPU address: `cpu_a` as given. A write with `cpu_a` ≥ `RAM_WORDS` completes normally but never asserts `sram_we`. A read with `cpu_a` ≥ `RAM_WORDS` returns 8'hFF.
- ACCESS: `sram_we` = 1 for exactly this cycle when an in-range CPU write is pending; otherwise `sram_we` = 0.
- READ: `sram_q` is valid. At the end of the cycle, capture into `cpu_q` (CPU read) or `ch_q` (channel), and set the winner's ack.
- DONE: the ack is high. It clears at the end of the cycle.
- Requests are latched only at grant. Changes to `req`, `we`, address or data after grant are ignored until the next IDLE.
- The requester drops `req` on the clock edge that ends DONE. A `req` still high in the following IDLE is treated as a new request.
- Reset (asynchronous, any state): state = IDLE, `rr` = 0. All outputs = 0: `cpu_ack`, `ch_ack`, `cpu_q`, `ch_q`, `sram_we`, `sram_a`, `sram_d`. An access in flight is abandoned with no ack. A write is abandoned before ACCESS, or in ACCESS with `sram_we` forced low.

## Timing
- Grant edge E0 (end of IDLE), RAM capture E1, data capture E2, ack high for the cycle E2→E3.
- Latency is 3 cycles from a `req` seen in IDLE to the ack. A lone requester gets 4 cycles per access.
- `sram_a`/`sram_d` stay stable from E0 until the next grant.
- Worst-case wait for a channel with all six requesting is 5 accesses = 20 cycles before its own grant.

## Configuration
- `WTS_CPU_PRIORITY_EN` defined: in IDLE the CPU wins whenever `cpu_req` = 1. Channels round-robin among themselves, and `rr` advances only over channel slots 0..4.
- Undefined: pure six-way round-robin as described above.

## Test plan
- Reset mid-ACCESS of a CPU write to 12 with data 0x5A: `sram_we` never pulses; all outputs are 0. A subsequent CPU read of 12 returns the prior contents.
- CPU write 0x3C to 10'd300, then CPU read of 300: `sram_we` is high for exactly one cycle with `sram_a` = 300. The read ack comes 3 cycles after its req and `cpu_q` = 0x3C.
- Channel 3 offset 7'd5 read with RAM[389] = 0xA7: `sram_a` = 389, `ch_ack` = 5'b01000, `ch_q` = 0xA7.
- All five channels plus the CPU requesting continuously from reset (without macro): grants go ch0, ch1, ch2, ch3, ch4, cpu, ch0, with acks every 4 cycles.
- CPU write to 700 then read of 700: no `sram_we` pulse, write is acked, read returns 0xFF.
- With `WTS_CPU_PRIORITY_EN`, all requesting: the CPU wins every arbitration while `cpu_req` is held. The channels still rotate ch0..ch4 in the gaps between CPU requests.

Source files
------------

// File: rtl/wts_ram_arbiter.sv
// Wave-table RAM arbiter: serialises CPU and five channel fetches onto one single-port RAM.
// Build option: define WTS_CPU_PRIORITY_EN to let the CPU pre-empt the channel rotation.
module wts_ram_arbiter #(
  parameter int RAM_WORDS = 640
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_a,
  input  logic [7:0]  cpu_d,
  output logic        cpu_ack,
  output logic [7:0]  cpu_q,
  input  logic [4:0]  ch_req,
  input  logic [34:0] ch_addr,
  output logic [4:0]  ch_ack,
  output logic [7:0]  ch_q,
  output logic        sram_we,
  output logic [9:0]  sram_a,
  output logic [7:0]  sram_d,
  input  logic [7:0]  sram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

  localparam logic [2:0]  CPU_ID     = 3'd5;
  localparam logic [10:0] WORD_LIMIT = 11'(RAM_WORDS);

  state_t     state;
  logic [2:0] rr;
  logic [2:0] win_id;
  logic       win_we;
  logic       win_oor;

  logic       grant_valid;
  logic [2:0] grant_id;
  logic [6:0] grant_off;
  logic [3:0] cand;
  logic       cpu_in_range;
  logic [5:0] req_vec;

  assign req_vec      = {cpu_req, ch_req};
  assign cpu_in_range = {1'b0, cpu_a} < WORD_LIMIT;

  // NOTE: combinational logic uses blocking '=' and gives every target a default first, so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
`ifdef WTS_CPU_PRIORITY_EN
    if (cpu_req) begin
      grant_valid = 1'b1;
      grant_id    = CPU_ID;
    end
    for (int i = 0; i < 5; i++) begin
      cand = {1'b0, rr} + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!grant_valid && req_vec[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[2:0];
      end
    end
`else
    for (int i = 0; i < 6; i++) begin
      cand = {1'b0, rr} + 4'(i);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!grant_valid && req_vec[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[2:0];
      end
    end
`endif
  end

  // Wave offset of the winning channel; its page number forms the upper address bits.
  always_comb begin
    grant_off = '0;
    for (int n = 0; n < 5; n++) begin
      if (grant_id == 3'(n)) grant_off = ch_addr[7*n +: 7];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      rr      <= '0;
      win_id  <= '0;
      win_we  <= 1'b0;
      win_oor <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_q   <= '0;
      ch_ack  <= '0;
      ch_q    <= '0;
      sram_we <= 1'b0;
      sram_a  <= '0;
      sram_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state  <= ACCESS;
            win_id <= grant_id;
            if (grant_id == CPU_ID) begin
              sram_a  <= cpu_a;
              sram_d  <= cpu_d;
              win_we  <= cpu_we;
              win_oor <= !cpu_in_range;
              sram_we <= cpu_we && cpu_in_range;
            end else begin
              sram_a  <= {grant_id, grant_off};
              sram_d  <= '0;
              win_we  <= 1'b0;
              win_oor <= 1'b0;
            end
`ifdef WTS_CPU_PRIORITY_EN
            if (grant_id != CPU_ID) rr <= (grant_id == 3'd4) ? 3'd0 : grant_id + 3'd1;
`else
            rr <= (grant_id == CPU_ID) ? 3'd0 : grant_id + 3'd1;
`endif
          end
        end
        ACCESS: begin
          sram_we <= 1'b0;
          state   <= READ;
        end
        READ: begin
          state <= DONE;
          if (win_id == CPU_ID) begin
            cpu_ack <= 1'b1;
            // A write completion leaves the last read value on cpu_q.
            if (!win_we) cpu_q <= win_oor ? 8'hFF : sram_q;
          end else begin
            ch_ack <= 5'd1 << win_id;
            ch_q   <= sram_q;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          ch_ack  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wts_ram_arbiter.sv
// Randomised scoreboard bench for wts_ram_arbiter; a transaction-level model predicts
// grant order, RAM contents, write strobes and ack timing for each burst of requests.
module tb_wts_ram_arbiter;

  localparam int RAM_WORDS = 640;

  typedef struct { bit we; int a; logic [7:0] d; } txn_t;
  typedef struct { int id; logic [9:0] addr; logic [7:0] data; bit first; } exp_t;
  typedef struct { logic [9:0] a; logic [7:0] d; } wr_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0]  cpu_a = '0;
  logic [7:0]  cpu_d = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_q;
  logic [4:0]  ch_req = '0;
  logic [34:0] ch_addr = '0;
  logic [4:0]  ch_ack;
  logic [7:0]  ch_q;
  logic        sram_we;
  logic [9:0]  sram_a;
  logic [7:0]  sram_d;
  logic [7:0]  sram_q;

  always #5 clk = ~clk;

  wts_ram_arbiter #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_ack(cpu_ack), .cpu_q(cpu_q),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_q(ch_q),
    .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Wave-table RAM with registered read data.
  logic [7:0] mem [RAM_WORDS];
  always @(posedge clk) begin
    if (sram_we && int'(sram_a) < RAM_WORDS) mem[sram_a] <= sram_d;
    sram_q <= (int'(sram_a) < RAM_WORDS) ? mem[sram_a] : 8'h00;
  end

  logic [7:0] ref_mem [RAM_WORDS];
  txn_t       pend [6][$];
  exp_t       exp_q [$];
  wr_t        exp_wr [$];
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, burst_cyc = 0, last_ack_cyc = 0;
  int         model_rr = 0;
  logic [7:0] last_cpu_rd = 8'h00;
  int         pop_id = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
    check({tag, "_ch_ack"},  32'(ch_ack),  0);
    check({tag, "_cpu_q"},   32'(cpu_q),   0);
    check({tag, "_ch_q"},    32'(ch_q),    0);
    check({tag, "_sram_we"}, 32'(sram_we), 0);
    check({tag, "_sram_a"},  32'(sram_a),  0);
    check({tag, "_sram_d"},  32'(sram_d),  0);
  endtask

  // Present the head transaction of every requester; idle CPU inputs carry junk.
  task automatic drive();
    cpu_req = pend[5].size() != 0;
    cpu_we  = 1'($urandom);
    cpu_a   = 10'($urandom);
    cpu_d   = 8'($urandom);
    if (cpu_req) begin
      cpu_we = pend[5][0].we;
      cpu_a  = 10'(pend[5][0].a);
      cpu_d  = pend[5][0].d;
    end
    for (int n = 0; n < 5; n++) begin
      ch_req[n] = pend[n].size() != 0;
      ch_addr[7*n +: 7] = ch_req[n] ? 7'(pend[n][0].a) : 7'($urandom);
    end
  endtask

  function automatic bit busy();
    for (int k = 0; k < 6; k++) if (pend[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Replay the pending requests through the arbitration rules and predict every completion.
  task automatic predict();
    txn_t cp [6][$];
    txn_t t;
    bit   first = 1'b1;
    int   w;
    for (int k = 0; k < 6; k++) cp[k] = pend[k];
    while (1) begin
      w = -1;
`ifdef WTS_CPU_PRIORITY_EN
      if (cp[5].size() != 0) w = 5;
      else for (int i = 0; i < 5; i++) if (w < 0 && cp[(model_rr + i) % 5].size() != 0) w = (model_rr + i) % 5;
`else
      for (int i = 0; i < 6; i++) if (w < 0 && cp[(model_rr + i) % 6].size() != 0) w = (model_rr + i) % 6;
`endif
      if (w < 0) break;
      t = cp[w][0];
      cp[w].delete(0);
      if (w == 5) begin
        if (t.we) begin
          if (t.a < RAM_WORDS) begin
            ref_mem[t.a] = t.d;
            exp_wr.push_back('{a: 10'(t.a), d: t.d});
          end
        end else begin
          last_cpu_rd = (t.a < RAM_WORDS) ? ref_mem[t.a] : 8'hFF;
        end
        exp_q.push_back('{id: 5, addr: 10'(t.a), data: last_cpu_rd, first: first});
      end else begin
        exp_q.push_back('{id: w, addr: 10'(w * 128 + t.a), data: ref_mem[w * 128 + t.a], first: first});
      end
      first = 1'b0;
`ifdef WTS_CPU_PRIORITY_EN
      if (w != 5) model_rr = (w + 1) % 5;
`else
      model_rr = (w + 1) % 6;
`endif
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 6; k++) pend[k].delete();
    exp_q.delete();
    exp_wr.delete();
    model_rr    = 0;
    last_cpu_rd = 8'h00;
  endtask

  task automatic issue();
    predict();
    burst_cyc = cyc;
    drive();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy() || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      fail({"timeout_", name});
      nreset = 1'b0;
      clear_model();
      drive();
      @(posedge clk);
      #1 nreset = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Requester behaviour: retire the acknowledged transaction on the edge that ends DONE.
  always @(posedge clk) begin
    if (pop_id >= 0) begin
      #1;
      if (pend[pop_id].size() != 0) pend[pop_id].delete(0);
      pop_id = -1;
      drive();
    end
  end

  // Monitor: compares write strobes and completions against the scoreboard.
  always @(negedge clk) begin
    if (nreset && sram_we) begin
      if (exp_wr.size() == 0) fail("sram_we_spurious");
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("sram_we_addr", 32'(sram_a), 32'(w.a));
        check("sram_we_data", 32'(sram_d), 32'(w.d));
      end
    end
    if (cpu_ack || ch_ack != 5'd0) begin
      if (exp_q.size() == 0) fail("ack_unexpected");
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack_cpu", 32'(cpu_ack), (e.id == 5) ? 32'd1 : 32'd0);
        check("ack_ch", 32'(ch_ack), (e.id == 5) ? 32'd0 : 32'd1 << e.id);
        check("ack_sram_a", 32'(sram_a), 32'(e.addr));
        if (e.id == 5) check("cpu_q", 32'(cpu_q), 32'(e.data));
        else           check("ch_q", 32'(ch_q), 32'(e.data));
        if (e.first) check("ack_latency", 32'(cyc - burst_cyc), 3);
        else         check("ack_spacing", 32'(cyc - last_ack_cyc), 4);
      end
      last_ack_cyc = cyc;
      if (cpu_ack) pop_id = 5;
      else for (int n = 4; n >= 0; n--) if (ch_ack[n]) pop_id = n;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [7:0] prev12;
    for (int i = 0; i < RAM_WORDS; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    clear_model();
    drive();
    #13;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;

    // Everyone requesting from reset: ch0..ch4, cpu, ch0 ... at 4-cycle spacing.
    for (int k = 0; k < 5; k++) repeat (2) pend[k].push_back('{we: 1'b0, a: $urandom_range(0, 127), d: 8'h00});
    repeat (2) pend[5].push_back('{we: 1'b0, a: $urandom_range(0, 639), d: 8'h00});
    issue();
    wait_done("all_six");

    // Write then read back at 300.
    pend[5].push_back('{we: 1'b1, a: 300, d: 8'h3C});
    pend[5].push_back('{we: 1'b0, a: 300, d: 8'h00});
    issue();
    wait_done("wr_rd_300");

    // Channel 3, offset 5 -> word 389.
    mem[389]     = 8'hA7;
    ref_mem[389] = 8'hA7;
    pend[3].push_back('{we: 1'b0, a: 5, d: 8'h00});
    issue();
    wait_done("ch3_off5");

    // Out-of-range CPU write is acked without a strobe; the read returns 0xFF.
    pend[5].push_back('{we: 1'b1, a: 700, d: 8'h55});
    pend[5].push_back('{we: 1'b0, a: 700, d: 8'h00});
    issue();
    wait_done("oor_700");

    // Reset during ACCESS of a write to 12: nothing may reach the RAM.
    prev12  = ref_mem[12];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'd12; cpu_d = 8'h5A;
    @(posedge clk);
    #1 nreset = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_outputs_zero("mid_access_reset");
    clear_model();
    drive();
    @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
    check("ref_mem12_kept", 32'(ref_mem[12]), 32'(prev12));
    pend[5].push_back('{we: 1'b0, a: 12, d: 8'h00});
    issue();
    wait_done("read_12");

    // Random bursts from random subsets of requesters.
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 3)) begin
            if (k == 5)
              pend[5].push_back('{we: 1'($urandom),
                                  a: ($urandom_range(0, 9) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639),
                                  d: 8'($urandom)});
            else
              pend[k].push_back('{we: 1'b0, a: $urandom_range(0, 127), d: 8'h00});
          end
        end
      end
      if (busy()) begin
        issue();
        wait_done("random_burst");
      end
    end

    check("leftover_acks", 32'(exp_q.size()), 0);
    check("leftover_writes", 32'(exp_wr.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
